// File: rtl/stream_acc_pkg.sv
// Shared helpers for the stream group accumulator: derived counter width and
// the saturating adder used when STREAM_GROUP_ACC_SATURATE_EN is defined.
package stream_acc_pkg;

  // Counter must hold values 0..group_size, so it needs one more code than group_size.
  function automatic int calc_cnt_width(input int group_size);
    return $clog2(group_size + 1);
  endfunction

  // Unsigned add clamped to 2^out_width-1; operands and result carried in 64 bits.
  function automatic logic [63:0] sat_add(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input int          out_width);
    logic [64:0] sum;
    logic [64:0] limit;
    sum   = {1'b0, a} + {1'b0, b};
    limit = (65'd1 << out_width) - 65'd1;
    return (sum > limit) ? limit[63:0] : sum[63:0];
  endfunction

endpackage

// File: rtl/stream_group_accumulator.sv
// Sums a valid/ready item stream in groups of up to group_size items (or until
// up_last) and emits each total through a single registered output slot.
// Optional macro: STREAM_GROUP_ACC_SATURATE_EN selects saturating sums.
module stream_group_accumulator
  import stream_acc_pkg::*;
#(
  parameter int width      = 8,
  parameter int group_size = 4,
  parameter int out_width  = width + $clog2(group_size),
  parameter int cnt_width  = calc_cnt_width(group_size)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 up_valid,
  output logic                 up_ready,
  input  logic [width-1:0]     up_data,
  input  logic                 up_last,
  output logic                 down_valid,
  input  logic                 down_ready,
  output logic [out_width-1:0] down_data,
  output logic [cnt_width-1:0] down_count
);

  logic [out_width-1:0] acc;
  logic [cnt_width-1:0] cnt;
  logic                 closing;
  logic                 accept;
  logic                 drain;
  logic [out_width-1:0] sum;

  // Handshakes: a transfer happens on a cycle where valid && ready; valid never
  // depends on ready, and data is held stable while valid is high and ready low.
  // Only the item that closes a group needs the output slot, so it alone may stall.
  assign closing  = (cnt == cnt_width'(group_size - 1)) || up_last;
  assign up_ready = !closing || !down_valid || down_ready;
  assign accept   = up_valid && up_ready;
  assign drain    = down_valid && down_ready;

`ifdef STREAM_GROUP_ACC_SATURATE_EN
  assign sum = out_width'(sat_add(64'(acc), 64'(up_data), out_width));
`else
  assign sum = acc + out_width'(up_data);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      acc        <= '0;
      cnt        <= '0;
      down_valid <= 1'b0;
      down_data  <= '0;
      down_count <= '0;
    end else begin
      if (drain) begin
        down_valid <= 1'b0;
      end
      // A closing accept overrides the drain so back-to-back groups keep full rate.
      if (accept) begin
        if (closing) begin
          down_valid <= 1'b1;
          down_data  <= sum;
          down_count <= cnt + cnt_width'(1);
          acc        <= '0;
          cnt        <= '0;
        end else begin
          acc <= sum;
          cnt <= cnt + cnt_width'(1);
        end
      end
    end
  end

endmodule
